vga_text_writer: RTL and testbench

// - Writer side of the VGA text-mode display: accepts an ASCII byte stream and fills the character VRAM that the VGA scan-out reads.
//   The VGA scan-out indexes that VRAM by char column x[6:0] and char row y[4:0].
// - Maintains a cursor and handles CR/LF/backspace, auto line-wrap, screen clear at reset and end-of-screen handling.
// - Sits between the keyboard/console source and the VRAM write port, in the pclk domain.

---
 rtl/vga_text_writer_if.sv | 36 +++
 rtl/vga_text_writer.sv | 204 ++++++++++++++++++++
 tb/tb_vga_text_writer.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_text_writer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vga_text_writer_if                                            |
// | Purpose  : Bundles the character-stream handshake, the VRAM write/read   |
// |            ports and the cursor/status outputs of vga_text_writer.       |
// | Ports    : in_valid/in_char/in_ready   - ASCII stream handshake         |
// |            vram_we/vram_waddr/vram_wdata - VRAM write port {row,col}    |
// |            vram_raddr/vram_rdata       - VRAM read port (scroll copy)   |
// |            cur_x/cur_y/busy            - cursor position and status     |
// | Modports : master - char source / VRAM side, slave - the text writer.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface vga_text_writer_if;
  logic        in_valid;
  logic [7:0]  in_char;
  logic        in_ready;
  logic        vram_we;
  logic [11:0] vram_waddr;
  logic [7:0]  vram_wdata;
  logic [11:0] vram_raddr;
  logic [7:0]  vram_rdata;
  logic [6:0]  cur_x;
  logic [4:0]  cur_y;
  logic        busy;

  modport master (
    output in_valid, in_char, vram_rdata,
    input  in_ready, vram_we, vram_waddr, vram_wdata, vram_raddr, cur_x, cur_y, busy
  );

  modport slave (
    input  in_valid, in_char, vram_rdata,
    output in_ready, vram_we, vram_waddr, vram_wdata, vram_raddr, cur_x, cur_y, busy
  );
endinterface
`default_nettype wire

// File: rtl/vga_text_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vga_text_writer                                               |
// | Purpose  : Writer side of the VGA text-mode display. Accepts an ASCII    |
// |            byte stream, keeps a cursor, handles CR/LF/BS, line wrap,    |
// |            clears the character VRAM after reset and handles the end    |
// |            of the screen.                                                |
// | Ports    : pclk  - pixel clock, all logic on the rising edge            |
// |            reset - synchronous, active-high                              |
// |            bus   - vga_text_writer_if.slave (stream, VRAM, cursor)      |
// | Options  : TERM_SCROLL_EN - when defined, end of screen scrolls the      |
// |            display up one row (COPY then CLEAR of the last row); when   |
// |            undefined, the cursor wraps to row 0 and only row 0 is       |
// |            cleared, and the VRAM read port is unused (raddr held at 0). |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module vga_text_writer #(
  parameter int         COLS  = 70,
  parameter int         ROWS  = 30,
  parameter logic [7:0] BLANK = 8'h20
) (
  input wire logic          pclk,
  input wire logic          reset,
  vga_text_writer_if.slave  bus
);

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_COPY  = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  state_t      state_q;
  logic        in_ready_q;
  logic        busy_q;
  logic        we_q;
  logic [11:0] waddr_q;
  logic [7:0]  wdata_q;
  logic [6:0]  cur_x_q;
  logic [4:0]  cur_y_q;
  // Sweep counters shared by INIT, COPY (read address) and CLEAR.
  logic [6:0]  col_q;
  logic [4:0]  row_q;
  // Set once the final write of an INIT/CLEAR sweep has been issued, so the
  // machine only reopens the input after that write has left the port.
  logic        last_q;
`ifdef TERM_SCROLL_EN
  logic [11:0] raddr_q;
  // Current write carries read data straight from the VRAM read port.
  logic        copy_wr_q;
`endif

  logic accept;
  logic printable;
  logic line_adv;

  assign accept    = in_ready_q & bus.in_valid;
  assign printable = (bus.in_char >= 8'h20) && (bus.in_char <= 8'h7E);
  // Printing into the last column advances the line instead of incrementing.
  assign line_adv  = (bus.in_char == CH_LF) || (printable && (cur_x_q == LAST_COL));

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q    <= S_INIT;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b1;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= BLANK;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      last_q     <= 1'b0;
`ifdef TERM_SCROLL_EN
      raddr_q    <= '0;
      copy_wr_q  <= 1'b0;
`endif
    end else begin
      we_q <= 1'b0;
`ifdef TERM_SCROLL_EN
      copy_wr_q <= 1'b0;
`endif
      case (state_q)
        // INIT sweeps every row; CLEAR sweeps only row_q.
        S_INIT, S_CLEAR: begin
          if (last_q) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            last_q     <= 1'b0;
          end else begin
            we_q    <= 1'b1;
            waddr_q <= {row_q, col_q};
            wdata_q <= BLANK;
            if (col_q == LAST_COL) begin
              col_q <= '0;
              if ((state_q == S_CLEAR) || (row_q == LAST_ROW)) begin
                last_q <= 1'b1;
              end else begin
                row_q <= row_q + 5'd1;
              end
            end else begin
              col_q <= col_q + 7'd1;
            end
          end
        end

        S_IDLE: begin
          if (accept) begin
            if (printable) begin
              we_q    <= 1'b1;
              waddr_q <= {cur_y_q, cur_x_q};
              wdata_q <= bus.in_char;
            end

            if (line_adv) begin
              cur_x_q <= '0;
              if (cur_y_q != LAST_ROW) begin
                cur_y_q <= cur_y_q + 5'd1;
              end else begin
                in_ready_q <= 1'b0;
                busy_q     <= 1'b1;
                col_q      <= '0;
                last_q     <= 1'b0;
`ifdef TERM_SCROLL_EN
                state_q    <= S_COPY;
                row_q      <= 5'd1;
                raddr_q    <= {5'd1, 7'd0};
`else
                state_q    <= S_CLEAR;
                row_q      <= '0;
                cur_y_q    <= '0;
`endif
              end
            end else if (printable) begin
              cur_x_q <= cur_x_q + 7'd1;
            end else if (bus.in_char == CH_CR) begin
              cur_x_q <= '0;
            end else if ((bus.in_char == CH_BS) && (cur_x_q != 7'd0)) begin
              cur_x_q <= cur_x_q - 7'd1;
              we_q    <= 1'b1;
              waddr_q <= {cur_y_q, cur_x_q - 7'd1};
              wdata_q <= BLANK;
            end
          end
        end

`ifdef TERM_SCROLL_EN
        // raddr_q presents cell (row_q,col_q); its data arrives next cycle and
        // is written one row up in that same cycle.
        S_COPY: begin
          we_q      <= 1'b1;
          copy_wr_q <= 1'b1;
          waddr_q   <= {row_q - 5'd1, col_q};
          if (col_q == LAST_COL) begin
            col_q <= '0;
            if (row_q == LAST_ROW) begin
              // row_q stays on the last row, which CLEAR blanks next.
              state_q <= S_CLEAR;
            end else begin
              row_q   <= row_q + 5'd1;
              raddr_q <= {row_q + 5'd1, 7'd0};
            end
          end else begin
            col_q   <= col_q + 7'd1;
            raddr_q <= {row_q, col_q + 7'd1};
          end
        end
`endif

        default: begin
          state_q <= S_INIT;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.busy       = busy_q;
  assign bus.vram_we    = we_q;
  assign bus.vram_waddr = waddr_q;
  assign bus.cur_x      = cur_x_q;
  assign bus.cur_y      = cur_y_q;

`ifdef TERM_SCROLL_EN
  assign bus.vram_wdata = copy_wr_q ? bus.vram_rdata : wdata_q;
  assign bus.vram_raddr = raddr_q;
`else
  assign bus.vram_wdata = wdata_q;
  assign bus.vram_raddr = '0;
  logic unused_rdata;
  assign unused_rdata = ^bus.vram_rdata;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_text_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_vga_text_writer                                            |
// | Purpose  : Self-checking bench for vga_text_writer: reset/INIT sweep,   |
// |            table of single-char vectors, line wrap, end of screen,      |
// |            reset mid-operation and a random stream against a screen     |
// |            model. Follows TERM_SCROLL_EN like the design.                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_vga_text_writer;

  localparam int         COLS  = 70;
  localparam int         ROWS  = 30;
  localparam logic [7:0] BLANK = 8'h20;

  logic pclk  = 1'b0;
  logic reset = 1'b1;
  always #5 pclk = ~pclk;

  vga_text_writer_if bus ();

  vga_text_writer #(.COLS(COLS), .ROWS(ROWS), .BLANK(BLANK)) dut (
    .pclk  (pclk),
    .reset (reset),
    .bus   (bus)
  );

  // VRAM: synchronous write, registered read (data valid one cycle later).
  logic [7:0] vram [0:4095];
  logic [7:0] rdata_q;
  int         bad_addr = 0;
  assign bus.vram_rdata = rdata_q;

  always @(posedge pclk) begin
    if (bus.vram_we) begin
      vram[bus.vram_waddr] <= bus.vram_wdata;
      if ((bus.vram_waddr[6:0] >= 7'(COLS)) || (bus.vram_waddr[11:7] >= 5'(ROWS)))
        bad_addr <= bad_addr + 1;
    end
    rdata_q <= vram[bus.vram_raddr];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] addr(input int r, input int c);
    return {5'(r), 7'(c)};
  endfunction

  // Screen model: what each cell should hold and where the cursor should be.
  logic [7:0] scr [ROWS][COLS];
  int mx, my;

  function automatic void model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) scr[r][c] = BLANK;
    mx = 0;
    my = 0;
  endfunction

  function automatic void model_newline();
    mx = 0;
    if (my < ROWS - 1) begin
      my++;
    end else begin
`ifdef TERM_SCROLL_EN
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++) scr[r][c] = scr[r + 1][c];
      for (int c = 0; c < COLS; c++) scr[ROWS - 1][c] = BLANK;
`else
      my = 0;
      for (int c = 0; c < COLS; c++) scr[0][c] = BLANK;
`endif
    end
  endfunction

  function automatic void model_apply(input logic [7:0] ch);
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      scr[my][mx] = ch;
      if (mx == COLS - 1) model_newline();
      else mx++;
    end else if (ch == 8'h0A) begin
      model_newline();
    end else if (ch == 8'h0D) begin
      mx = 0;
    end else if (ch == 8'h08) begin
      if (mx > 0) begin
        mx--;
        scr[my][mx] = BLANK;
      end
    end
  endfunction

  // Called at a negedge. Returns at the negedge of the cycle after acceptance.
  task automatic send(input logic [7:0] ch);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_char  = ch;
    while (!bus.in_ready && n < 5000) begin
      @(negedge pclk);
      n++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 0, 1);
      bus.in_valid = 1'b0;
    end else begin
      model_apply(ch);
      @(negedge pclk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    int n = 0, oerr = 0, derr = 0, cyc = 0;
    bus.in_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge pclk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_we", bus.vram_we, 0);
    check("rst_waddr", bus.vram_waddr, 0);
    check("rst_wdata", bus.vram_wdata, BLANK);
    check("rst_raddr", bus.vram_raddr, 0);
    check("rst_cur", {bus.cur_y, bus.cur_x}, 0);
    check("rst_busy", bus.busy, 1);
    reset = 1'b0;
    model_clear();
    @(negedge pclk);
    check("init_busy", bus.busy, 1);
    while (!bus.in_ready && cyc < 3000) begin
      if (bus.vram_we) begin
        if (bus.vram_waddr != addr(n / COLS, n % COLS)) oerr++;
        if (bus.vram_wdata != BLANK) derr++;
        n++;
      end
      cyc++;
      @(negedge pclk);
    end
    check("init_writes", n, ROWS * COLS);
    check("init_order_errs", oerr, 0);
    check("init_data_errs", derr, 0);
    check("init_in_ready", bus.in_ready, 1);
    check("init_busy_end", bus.busy, 0);
    check("init_cur", {bus.cur_y, bus.cur_x}, 0);
  endtask

  task automatic compare_screen(input string name);
    int mism = 0;
    @(negedge pclk);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (vram[addr(r, c)] != scr[r][c]) mism++;
    check(name, mism, 0);
    check({name, "_cur_x"}, bus.cur_x, mx);
    check({name, "_cur_y"}, bus.cur_y, my);
  endtask

  typedef struct {
    logic [7:0]  ch;
    bit          we;
    logic [11:0] waddr;
    logic [7:0]  wdata;
    int          x;
    int          y;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [7:0] ch, input bit we, input int r, input int c,
                     input logic [7:0] d, input int x, input int y);
    vec_t v;
    v.ch = ch; v.we = we; v.waddr = addr(r, c); v.wdata = d; v.x = x; v.y = y;
    tbl.push_back(v);
  endtask

  initial begin
    int low, nw, bad, wait_n;
    logic [7:0] ch;

    bus.in_valid = 1'b0;
    bus.in_char  = 8'h00;

    // Vectors applied in order from cursor (0,0) after INIT.
    add(8'h41, 1, 0, 0, 8'h41, 1, 0);   // 'A'
    add(8'h0D, 0, 0, 0, 8'h00, 0, 0);   // CR
    add(8'h0A, 0, 0, 0, 8'h00, 0, 1);   // LF
    add(8'h78, 1, 1, 0, 8'h78, 1, 1);   // 'x'
    add(8'h79, 1, 1, 1, 8'h79, 2, 1);   // 'y'
    add(8'h08, 1, 1, 1, BLANK, 1, 1);   // BS
    add(8'h07, 0, 0, 0, 8'h00, 1, 1);   // BEL consumed
    add(8'h08, 1, 1, 0, BLANK, 0, 1);   // BS to col 0
    add(8'h08, 0, 0, 0, 8'h00, 0, 1);   // BS at col 0: no-op
    add(8'h7E, 1, 1, 0, 8'h7E, 1, 1);   // '~' last printable
    add(8'h7F, 0, 0, 0, 8'h00, 1, 1);   // DEL not printable
    add(8'h1F, 0, 0, 0, 8'h00, 1, 1);
    add(8'h0A, 0, 0, 0, 8'h00, 0, 2);   // LF
    add(8'h20, 1, 2, 0, 8'h20, 1, 2);   // space is printable
    add(8'hFF, 0, 0, 0, 8'h00, 1, 2);

    do_reset();
    foreach (tbl[i]) begin
      send(tbl[i].ch);
      check($sformatf("vec%0d_we", i), bus.vram_we, tbl[i].we);
      if (tbl[i].we) begin
        check($sformatf("vec%0d_waddr", i), bus.vram_waddr, tbl[i].waddr);
        check($sformatf("vec%0d_wdata", i), bus.vram_wdata, tbl[i].wdata);
      end
      check($sformatf("vec%0d_cur_x", i), bus.cur_x, tbl[i].x);
      check($sformatf("vec%0d_cur_y", i), bus.cur_y, tbl[i].y);
    end
    compare_screen("vec_screen");

    // Full row of 'B' wraps to the next line; BS at col 0 is a no-op.
    do_reset();
    bad = 0;
    for (int i = 0; i < COLS; i++) begin
      send(8'h42);
      if (!bus.vram_we || bus.vram_waddr != addr(0, i) || bus.vram_wdata != 8'h42) bad++;
    end
    check("wrap_write_errs", bad, 0);
    check("wrap_cur", {bus.cur_y, bus.cur_x}, {5'd1, 7'd0});
    send(8'h08);
    check("wrap_bs_we", bus.vram_we, 0);
    check("wrap_bs_cur", {bus.cur_y, bus.cur_x}, {5'd1, 7'd0});

    // End of screen with a char held pending throughout.
    do_reset();
    for (int i = 0; i < ROWS - 1; i++) send(8'h0A);
    send(8'h51);                                  // mark row 29 col 0
    check("eos_pre_cur", {bus.cur_y, bus.cur_x}, {5'(ROWS - 1), 7'd1});
    send(8'h0A);
    bus.in_valid = 1'b1;
    bus.in_char  = 8'h5A;
    low = 0; nw = 0; bad = 0;
    while (!bus.in_ready && low < 5000) begin
      if (bus.vram_we) begin
        nw++;
`ifdef TERM_SCROLL_EN
        if (bus.vram_waddr[11:7] == 5'(ROWS - 1) && bus.vram_wdata != BLANK) bad++;
`else
        if (bus.vram_waddr[11:7] != 5'd0 || bus.vram_wdata != BLANK) bad++;
`endif
      end
      low++;
      @(negedge pclk);
    end
`ifdef TERM_SCROLL_EN
    check("eos_ready_low_cycles", low, (ROWS - 1) * COLS + 1 + COLS);
    check("eos_writes", nw, (ROWS - 1) * COLS + COLS);
`else
    check("eos_writes", nw, COLS);
`endif
    check("eos_bad_writes", bad, 0);
    model_apply(8'h5A);
    @(negedge pclk);
    bus.in_valid = 1'b0;
    check("eos_held_we", bus.vram_we, 1);
`ifdef TERM_SCROLL_EN
    check("eos_held_waddr", bus.vram_waddr, addr(ROWS - 1, 0));
`else
    check("eos_held_waddr", bus.vram_waddr, addr(0, 0));
`endif
    check("eos_held_wdata", bus.vram_wdata, 8'h5A);
    compare_screen("eos_screen");

    // Reset during the end-of-screen sweep restarts INIT from {0,0}.
    for (int i = 0; i < ROWS; i++) send(8'h0A);
    repeat (20) @(negedge pclk);
    check("midop_busy", bus.busy, 1);
    do_reset();

    // Random stream against the screen model, starting near the bottom.
    for (int i = 0; i < ROWS - 3; i++) send(8'h0A);
    for (int i = 0; i < 220; i++) begin
      int r;
      r = $urandom_range(99);
      if (r < 5)       ch = 8'h0A;
      else if (r < 8)  ch = 8'h0D;
      else if (r < 14) ch = 8'h08;
      else if (r < 18) ch = 8'($urandom_range(255));
      else             ch = 8'($urandom_range(8'h7E, 8'h20));
      repeat ($urandom_range(2)) @(negedge pclk);
      send(ch);
      check("rand_cur_x", bus.cur_x, mx);
      check("rand_cur_y", bus.cur_y, my);
    end
    wait_n = 0;
    while (!bus.in_ready && wait_n < 5000) begin
      @(negedge pclk);
      wait_n++;
    end
    check("rand_idle", bus.in_ready, 1);
    compare_screen("rand_screen");
    check("addr_range_errs", bad_addr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
